// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared lane count, bank-state encoding and bit-reverse helper.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int c_LANES     = 4;
    localparam int c_LANE_BITS = 2;

    localparam logic [1:0] c_BANK_FREE = 2'd0;
    localparam logic [1:0] c_BANK_FILL = 2'd1;
    localparam logic [1:0] c_BANK_FULL = 2'd2;

    // Reverses the low nbits of value; upper result bits are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int nbits);
        logic [31:0] result;
        result = '0;
        for (int i = 0; i < nbits; i++) begin
            result = {result[30:0], value[i]};
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_bank.sv
`default_nettype none
// ============================================================================
// Module   : reorder_bank
// Brief    : N-word register file, 4 synchronous write ports, 4 async read ports.
// Revision : 1.0
// ============================================================================
module reorder_bank
    import fft_pkg::*;
#(
    parameter int NBITS_out = 10,
    parameter int N         = 128,
    parameter int ADDR_W    = $clog2(N)
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [c_LANES*ADDR_W-1:0]          wrAddr,
    input  logic [c_LANES*2*NBITS_out-1:0]     wrData,
    input  logic [c_LANES*ADDR_W-1:0]          rdAddr,
    output logic [c_LANES*2*NBITS_out-1:0]     rdData
);

    localparam int c_DW = 2 * NBITS_out;

    logic [c_DW-1:0] r_mem [N];

    // The four write addresses of one beat are always distinct bins.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int l = 0; l < c_LANES; l++) begin
                r_mem[wrAddr[l*ADDR_W +: ADDR_W]] <= wrData[l*c_DW +: c_DW];
            end
        end
    end

    for (genvar l = 0; l < c_LANES; l++) begin : g_rd
        assign rdData[l*c_DW +: c_DW] = r_mem[rdAddr[l*ADDR_W +: ADDR_W]];
    end

endmodule
`default_nettype wire

// File: rtl/fft_out_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_out_reorder
// Brief    : Ping-pong reorder of 4-lane bit-reversed FFT output to natural
//            order. Define FFT_REORDER_DROPCNT_EN to add the drop_cnt output.
// Revision : 1.0
// ============================================================================
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int NBITS_out = 10,
    parameter int N         = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [2*NBITS_out-1:0] fftOut0_up,
    input  logic [2*NBITS_out-1:0] fftOut0_down,
    input  logic [2*NBITS_out-1:0] fftOut1_up,
    input  logic [2*NBITS_out-1:0] fftOut1_down,
    output logic [2*NBITS_out-1:0] dout0,
    output logic [2*NBITS_out-1:0] dout1,
    output logic [2*NBITS_out-1:0] dout2,
    output logic [2*NBITS_out-1:0] dout3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   overflow
`ifdef FFT_REORDER_DROPCNT_EN
    ,
    output logic [7:0]             drop_cnt
`endif
);

    localparam int c_DW = 2 * NBITS_out;
    localparam int c_AW = $clog2(N);
    localparam int c_BW = c_AW - c_LANE_BITS;
    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(N / c_LANES - 1);

    logic [1:0]              r_bankState [2];
    logic [1:0]              w_nextState [2];
    logic                    r_fillBank;
    logic [c_BW-1:0]         r_wrBeat;
    logic                    r_rdBank;
    logic [c_BW-1:0]         r_rdBeat;
    logic                    r_outBank;
    logic                    r_outValid;
    logic                    r_outLast;
    logic                    r_overflow;
    logic [c_DW-1:0]         r_dout [c_LANES];

    logic [1:0]              w_release;
    logic [1:0]              w_free;
    logic [1:0]              w_becomesFull;
    logic                    w_filling;
    logic                    w_freeAvail;
    logic                    w_newBank;
    logic                    w_outAccept;
    logic                    w_sofTake;
    logic                    w_drop;
    logic                    w_write;
    logic                    w_wrBank;
    logic                    w_wrDone;
    logic                    w_loadOut;
    logic                    w_issue;
    logic                    w_issueLast;
    logic [c_BW-1:0]         w_wrBeat;
    logic [c_LANES*c_AW-1:0] w_wrAddr;
    logic [c_LANES*c_AW-1:0] w_rdAddr;
    logic [c_LANES*c_DW-1:0] w_wrData;
    logic [c_LANES*c_DW-1:0] w_rdData [2];
    logic [c_LANES*c_DW-1:0] w_rdSel;

    assign w_filling   = (r_bankState[0] == c_BANK_FILL) || (r_bankState[1] == c_BANK_FILL);
    assign w_outAccept = r_outValid && out_ready;

    // A bank whose last beat is accepted this cycle is already reusable.
    always_comb begin
        w_release = '0;
        w_free    = '0;
        for (int b = 0; b < 2; b++) begin
            w_release[b] = w_outAccept && r_outLast && (r_outBank == 1'(b));
            w_free[b]    = (r_bankState[b] == c_BANK_FREE) || w_release[b];
        end
    end

    assign w_freeAvail = |w_free;
    assign w_newBank   = !w_free[0];
    assign w_sofTake   = in_valid && in_sof && (w_filling || w_freeAvail);
    assign w_drop      = in_valid && in_sof && !w_filling && !w_freeAvail;
    assign w_write     = w_sofTake || (in_valid && !in_sof && w_filling);
    assign w_wrBank    = (in_sof && !w_filling) ? w_newBank : r_fillBank;
    assign w_wrBeat    = in_sof ? '0 : r_wrBeat;
    assign w_wrDone    = w_write && (w_wrBeat == c_LAST_BEAT);

    assign w_loadOut   = !r_outValid || out_ready;
    assign w_issue     = w_loadOut && (r_bankState[r_rdBank] == c_BANK_FULL);
    assign w_issueLast = w_issue && (r_rdBeat == c_LAST_BEAT);

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_nextState[b]   = r_bankState[b];
            w_becomesFull[b] = 1'b0;
            if (w_release[b]) begin
                w_nextState[b] = c_BANK_FREE;
            end
            if (w_write && (w_wrBank == 1'(b))) begin
                if (w_wrDone) begin
                    w_nextState[b]   = c_BANK_FULL;
                    w_becomesFull[b] = 1'b1;
                end else if (in_sof) begin
                    w_nextState[b] = c_BANK_FILL;
                end
            end
        end
    end

    assign w_wrData = {fftOut1_down, fftOut1_up, fftOut0_down, fftOut0_up};

    // Written at the bit-reversed bin, read back linearly in natural order.
    for (genvar l = 0; l < c_LANES; l++) begin : g_lane
        assign w_wrAddr[l*c_AW +: c_AW] = c_AW'(bitrev(32'({w_wrBeat, c_LANE_BITS'(l)}), c_AW));
        assign w_rdAddr[l*c_AW +: c_AW] = {r_rdBeat, c_LANE_BITS'(l)};
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank #(
            .NBITS_out (NBITS_out),
            .N         (N),
            .ADDR_W    (c_AW)
        ) u_bank (
            .clk    (clk),
            .we     (w_write && (w_wrBank == 1'(b))),
            .wrAddr (w_wrAddr),
            .wrData (w_wrData),
            .rdAddr (w_rdAddr),
            .rdData (w_rdData[b])
        );
    end

    assign w_rdSel = w_rdData[r_rdBank];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bankState[0] <= c_BANK_FREE;
            r_bankState[1] <= c_BANK_FREE;
            r_fillBank     <= 1'b0;
            r_wrBeat       <= '0;
            r_rdBank       <= 1'b0;
            r_rdBeat       <= '0;
            r_outBank      <= 1'b0;
            r_outValid     <= 1'b0;
            r_outLast      <= 1'b0;
            r_overflow     <= 1'b0;
            for (int l = 0; l < c_LANES; l++) begin
                r_dout[l] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_bankState[b] <= w_nextState[b];
            end
            if (w_write) begin
                r_fillBank <= w_wrBank;
                r_wrBeat   <= w_wrDone ? '0 : w_wrBeat + c_BW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_loadOut) begin
                r_outValid <= w_issue;
                r_outLast  <= w_issueLast;
                if (w_issue) begin
                    r_outBank <= r_rdBank;
                    r_rdBeat  <= w_issueLast ? '0 : r_rdBeat + c_BW'(1);
                    for (int l = 0; l < c_LANES; l++) begin
                        r_dout[l] <= w_rdSel[l*c_DW +: c_DW];
                    end
                end
            end
            // Oldest-first: a newly full bank becomes the read target only
            // when the other bank holds no older frame.
            if (w_issueLast) begin
                r_rdBank <= !r_rdBank;
            end
            for (int b = 0; b < 2; b++) begin
                if (w_becomesFull[b] && (r_bankState[1-b] != c_BANK_FULL)) begin
                    r_rdBank <= 1'(b);
                end
            end
        end
    end

`ifdef FFT_REORDER_DROPCNT_EN
    logic [7:0] r_dropCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dropCnt <= '0;
        end else if (w_drop && (r_dropCnt != 8'hFF)) begin
            r_dropCnt <= r_dropCnt + 8'd1;
        end
    end

    assign drop_cnt = r_dropCnt;
`endif

    assign dout0     = r_dout[0];
    assign dout1     = r_dout[1];
    assign dout2     = r_dout[2];
    assign dout3     = r_dout[3];
    assign out_valid = r_outValid;
    assign out_last  = r_outLast;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_out_reorder
// Brief    : Directed scoreboard bench for fft_out_reorder (N=128, 10-bit).
// Revision : 1.0
// ============================================================================
module tb_fft_out_reorder;

    localparam int NB    = 10;
    localparam int NN    = 128;
    localparam int BEATS = NN / 4;
    localparam int LOG2N = 7;

    typedef struct packed {
        logic        last;
        logic [79:0] data;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_sof;
    logic [2*NB-1:0] fftOut0_up, fftOut0_down, fftOut1_up, fftOut1_down;
    logic [2*NB-1:0] dout0, dout1, dout2, dout3;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           overflow;
`ifdef FFT_REORDER_DROPCNT_EN
    logic [7:0]     drop_cnt;
`endif

    exp_t sb[$];
    int   nVec = 0;
    int   nMis = 0;
    int   cyc = 0;
    int   sofCyc = 0;
    int   riseCyc = 0;
    int   beatCnt = 0;
    int   runLen = 0;
    int   maxRun = 0;
    logic prevValid = 1'b0;
    logic stallPrev = 1'b0;
    logic [80:0] stallWord = '0;

    fft_out_reorder #(.NBITS_out(NB), .N(NN)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .fftOut0_up   (fftOut0_up),
        .fftOut0_down (fftOut0_down),
        .fftOut1_up   (fftOut1_up),
        .fftOut1_down (fftOut1_down),
        .dout0        (dout0),
        .dout1        (dout1),
        .dout2        (dout2),
        .dout3        (dout3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .overflow     (overflow)
`ifdef FFT_REORDER_DROPCNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int brev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Frame 0 carries bin k as real=k, imag=0; other frames get a distinct pattern.
    function automatic logic [19:0] binWord(input int id, input int k);
        logic [9:0] re;
        logic [9:0] im;
        if (id == 0) begin
            re = 10'(k);
            im = '0;
        end else begin
            re = 10'(k * 5 + id * 17);
            im = 10'((k * 3) ^ (id * 29));
        end
        return {re, im};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pushFrame(input int id);
        exp_t e;
        for (int c = 0; c < BEATS; c++) begin
            for (int l = 0; l < 4; l++) e.data[l*20 +: 20] = binWord(id, 4 * c + l);
            e.last = (c == BEATS - 1);
            sb.push_back(e);
        end
    endtask

    task automatic sendFrame(input int id, input int nBeats, input bit push);
        if (push) pushFrame(id);
        for (int c = 0; c < nBeats; c++) begin
            if (c == 0) sofCyc = cyc;
            in_valid     = 1'b1;
            in_sof       = (c == 0);
            fftOut0_up   = binWord(id, brev(4 * c + 0));
            fftOut0_down = binWord(id, brev(4 * c + 1));
            fftOut1_up   = binWord(id, brev(4 * c + 2));
            fftOut1_down = binWord(id, brev(4 * c + 3));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        check(tag, 96'(sb.size()), 96'd0);
        repeat (40) begin
            @(posedge clk); #1;
        end
    endtask

    // Output monitor: scoreboard pops on handshake, stall hold, valid run length.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stallPrev = 1'b0;
                prevValid = 1'b0;
                runLen    = 0;
            end else begin
                if (stallPrev)
                    check("stall_hold", {out_valid, out_last, dout3, dout2, dout1, dout0}, {1'b1, stallWord});
                if (out_valid) begin
                    runLen++;
                    if (runLen > maxRun) maxRun = runLen;
                    if (!prevValid) riseCyc = cyc;
                end else begin
                    runLen = 0;
                end
                prevValid = out_valid;
                if (out_valid && out_ready) begin
                    beatCnt++;
                    check("beat_expected", 96'(sb.size() != 0), 96'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("beat_data", {out_last, dout3, dout2, dout1, dout0}, {e.last, e.data});
                    end
                end
                stallPrev = out_valid && !out_ready;
                stallWord = {out_last, dout3, dout2, dout1, dout0};
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        int start;
        int g;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        fftOut0_up = '0; fftOut0_down = '0; fftOut1_up = '0; fftOut1_down = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 96'(out_valid), 96'd0);
        check("rst_last", 96'(out_last), 96'd0);
        check("rst_overflow", 96'(overflow), 96'd0);
        check("rst_dout", {dout3, dout2, dout1, dout0}, 96'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single natural-ramp frame: latency, ordering, out_last
        sendFrame(0, BEATS, 1'b1);
        drain("f0_drain");
        check("f0_latency", 96'(riseCyc - sofCyc), 96'd33);
        check("f0_overflow", 96'(overflow), 96'd0);

        // Two back-to-back frames at full rate
        maxRun = 0;
        start = beatCnt;
        sendFrame(1, BEATS, 1'b1);
        sendFrame(2, BEATS, 1'b1);
        drain("b2b_drain");
        check("b2b_run", 96'(maxRun), 96'd64);
        check("b2b_beats", 96'(beatCnt - start), 96'd64);
        check("b2b_overflow", 96'(overflow), 96'd0);

        // Third frame dropped while downstream is stalled
        out_ready = 1'b0;
        start = beatCnt;
        sendFrame(3, BEATS, 1'b1);
        sendFrame(4, BEATS, 1'b1);
        sendFrame(5, BEATS, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("ovf_flag", 96'(overflow), 96'd1);
        check("ovf_valid_held", 96'(out_valid), 96'd1);
`ifdef FFT_REORDER_DROPCNT_EN
        check("ovf_drop_cnt", 96'(drop_cnt), 96'd1);
`endif
        out_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_beats", 96'(beatCnt - start), 96'd64);

        // sof re-asserted at beat 10: only the restarted frame comes out
        start = beatCnt;
        sendFrame(6, 10, 1'b0);
        sendFrame(7, BEATS, 1'b1);
        drain("restart_drain");
        check("restart_beats", 96'(beatCnt - start), 96'd32);

        // out_ready toggling every cycle
        start = beatCnt;
        fork
            sendFrame(8, BEATS, 1'b1);
            begin
                repeat (140) begin
                    out_ready = ~out_ready;
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        drain("toggle_drain");
        check("toggle_beats", 96'(beatCnt - start), 96'd32);

        // Reset during output beat 5, then a clean frame
        sendFrame(9, BEATS, 1'b1);
        start = beatCnt;
        g = 0;
        while (beatCnt < start + 5 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check("rst_mid_reach", 96'(beatCnt - start >= 5), 96'd1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check("rst_mid_valid", 96'(out_valid), 96'd0);
        check("rst_mid_overflow", 96'(overflow), 96'd0);
        check("rst_mid_dout", {out_last, dout3, dout2, dout1, dout0}, 96'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        start = beatCnt;
        sendFrame(10, BEATS, 1'b1);
        drain("post_rst_drain");
        check("post_rst_beats", 96'(beatCnt - start), 96'd32);
        check("post_rst_overflow", 96'(overflow), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_out_reorder.md
FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

Interface
REQ-001 SHALL have parameter NBITS_out, default 10: bits per real/imag component; each complex word is {real,imag}, 2*NBITS_out wide, signed two's complement.
REQ-002 SHALL have parameter N, default 128: FFT length, power of two, at least 8; one frame is N/4 beats.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-007 SHALL have port in_sof, input, 1 bit: first beat of a frame; qualified by in_valid.
REQ-008 SHALL have ports fftOut0_up, fftOut0_down, fftOut1_up and fftOut1_down, inputs, 2*NBITS_out each: FFT output lanes 0..3, in that order.
REQ-009 SHALL have ports dout0, dout1, dout2 and dout3, outputs, 2*NBITS_out each: natural-order lanes.
REQ-010 SHALL have port out_valid, output, 1 bit: output beat present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 SHALL have port out_last, output, 1 bit: final beat of a frame.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag set when a frame is dropped.

Function
REQ-014 SHALL treat input beat c (0..N/4-1), lane l (0..3), as bin bitrev_log2N(4c+l).
REQ-015 SHALL present bin 4c+l on dout<l> during output beat c.
REQ-016 SHALL buffer frames in two ping-pong banks of N words; each bank is FREE, FILL or FULL.
REQ-017 SHALL, on in_valid&&in_sof with a free bank available, start writing that bank (FREE->FILL) and write beat 0 to it.
REQ-018 SHALL choose the lower-index bank when both banks are free.
REQ-019 SHALL write each subsequent in_valid beat to the filling bank; FILL->FULL after beat N/4-1.
REQ-020 SHALL, on in_sof during FILL, discard the partial frame and restart at beat 0 in the same bank.
REQ-021 SHALL ignore in_valid without in_sof while no bank is in FILL.
REQ-022 SHALL, when in_sof arrives with no free bank, drop the whole frame (its N/4 beats are not written), set overflow and leave buffered frames intact.
REQ-023 SHALL count a bank as free in the same cycle that its final output beat is accepted.
REQ-024 SHALL assert out_valid the cycle after a bank reaches FULL, at the earliest (latency N/4+1 cycles from sof to the first output beat).
REQ-025 SHALL read banks oldest-frame first.
REQ-026 SHALL advance the read beat only on out_valid&&out_ready.
REQ-027 SHALL hold dout0..dout3 and out_last stable while out_valid&&!out_ready.
REQ-028 SHALL set out_last on read beat N/4-1 and return that bank to FREE on its handshake.
REQ-029 SHALL deliver back-to-back frames with out_ready held high at full rate, with no out_valid gap after the first frame.
REQ-030 SHALL pass data bit-exact, with no arithmetic and no width change.

Reset
REQ-031 SHALL, on rst, return both banks to FREE, clear all counters, drive out_valid, out_last and overflow to 0, and drive dout0..dout3 to 0 from the next edge.
REQ-032 SHALL discard all buffered and in-flight frames on rst and take effect within one cycle, including mid-frame.

Configuration
REQ-033 SHALL, with macro FFT_REORDER_DROPCNT_EN defined, add output drop_cnt[7:0]: count of dropped frames, saturating at 255, cleared by rst.
REQ-034 SHALL, without FFT_REORDER_DROPCNT_EN, omit that port and its logic and leave all other behaviour identical.

Structure
REQ-035 SHALL take the bitrev function, lane count constant 4 and bank-state encoding (FREE/FILL/FULL) from shared package fft_pkg.
REQ-036 SHALL instantiate sub-module reorder_bank twice: an N-word register file with 4 write ports and 4 read ports and a synchronous write.

Verification
REQ-037 SHALL cover: N=128, one frame carrying bin k as real=k, imag=0, out_ready=1 -> out_valid rises 33 cycles after sof, beat c gives 4c..4c+3, out_last on beat 31, overflow=0.
REQ-038 SHALL cover: two back-to-back frames with out_ready=1 -> 64 consecutive valid beats, overflow=0.
REQ-039 SHALL cover: out_ready=0 while three frames arrive -> third frame dropped, overflow=1, drop_cnt=1 (if FFT_REORDER_DROPCNT_EN); after out_ready=1, frames 1 then 2 emitted in order.
REQ-040 SHALL cover: in_sof re-asserted at beat 10 -> only the restarted frame is emitted, as 32 beats.
REQ-041 SHALL cover: out_ready toggling every cycle -> dout0..dout3 stable across stalls and frame content unchanged.
REQ-042 SHALL cover: rst at output beat 5 -> out_valid=0 and overflow=0 on the next cycle, and a following frame is emitted correctly.
